// File: rtl/vga_scanout_pkg.sv
// Shared timing defaults, widths and small helpers for the VGA scanout block.
package vga_scanout_pkg;

  localparam int unsigned HActive   = 640;
  localparam int unsigned HFp       = 16;
  localparam int unsigned HSync     = 96;
  localparam int unsigned HBp       = 48;
  localparam int unsigned VActive   = 480;
  localparam int unsigned VFp       = 10;
  localparam int unsigned VSync     = 2;
  localparam int unsigned VBp       = 33;
  localparam int unsigned ClkDiv    = 2;
  localparam int unsigned ScaleLog2 = 2;
  localparam int unsigned FbW       = 160;
  localparam logic [15:0] BaseAddr  = 16'h0000;

  localparam int unsigned CntW = 12;
  localparam int unsigned RgbW = 9;

  typedef logic [CntW-1:0] cnt_t;
  typedef logic [15:0]     vaddr_t;
  typedef logic [RgbW-1:0] rgb_t;  // {R[8:6], G[5:3], B[2:0]}

  typedef struct packed {
    logic hsync_n;
    logic vsync_n;
    logic de;
  } vid_ctl_t;

  localparam rgb_t     ColBlack = 9'h000;
  localparam vid_ctl_t CtlIdle  = '{hsync_n: 1'b1, vsync_n: 1'b1, de: 1'b0};

  function automatic logic in_window(input cnt_t x, input int unsigned lo,
                                     input int unsigned len);
    return (32'(x) >= lo) && (32'(x) < lo + len);
  endfunction

endpackage

// File: rtl/vga_scanout_if.sv
// VRAM read port shared between the scanout reader (master) and the VRAM (slave).
interface vga_scanout_if;

  vga_scanout_pkg::vaddr_t Address_bus;
  vga_scanout_pkg::rgb_t   Data_bus;
  logic                    rw;
  logic                    cs;
  logic                    oe;

  modport master (output Address_bus, output rw, output cs, output oe, input Data_bus);
  modport slave  (input Address_bus, input rw, input cs, input oe, output Data_bus);

endinterface

// File: rtl/vga_scanout_timing_gen.sv
// Pixel-tick divider, horizontal/vertical counters and raw (undelayed) timing flags.
module vga_scanout_timing_gen
  import vga_scanout_pkg::*;
#(
  parameter int unsigned H_ACTIVE = HActive,
  parameter int unsigned H_FP     = HFp,
  parameter int unsigned H_SYNC   = HSync,
  parameter int unsigned H_BP     = HBp,
  parameter int unsigned V_ACTIVE = VActive,
  parameter int unsigned V_FP     = VFp,
  parameter int unsigned V_SYNC   = VSync,
  parameter int unsigned V_BP     = VBp,
  parameter int unsigned CLK_DIV  = ClkDiv
) (
  input  logic     clk,
  input  logic     rst,
  output logic     o_tick,
  output cnt_t     o_h_cnt,
  output cnt_t     o_v_cnt,
  output logic     o_h_wrap,
  output logic     o_v_wrap,
  output vid_ctl_t o_ctl,
  output logic     o_vblank,
  output logic     o_frame_start
);

  localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DivW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DivW-1:0] r_div;
  cnt_t            r_h_cnt;
  cnt_t            r_v_cnt;
  logic            r_frame_start;
  logic            w_tick;
  logic            w_h_end;
  logic            w_v_end;

  assign w_tick  = (r_div == DivW'(CLK_DIV - 1));
  assign w_h_end = (r_h_cnt == cnt_t'(HTotal - 1));
  assign w_v_end = (r_v_cnt == cnt_t'(VTotal - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div         <= '0;
      r_h_cnt       <= '0;
      r_v_cnt       <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_div         <= w_tick ? '0 : r_div + 1'b1;
      // Marks the clk right after v_cnt steps into the first blanking line.
      r_frame_start <= w_tick && w_h_end && (r_v_cnt == cnt_t'(V_ACTIVE - 1));
      if (w_tick) begin
        r_h_cnt <= w_h_end ? '0 : r_h_cnt + 1'b1;
        if (w_h_end) r_v_cnt <= w_v_end ? '0 : r_v_cnt + 1'b1;
      end
    end
  end

  assign o_tick        = w_tick;
  assign o_h_cnt       = r_h_cnt;
  assign o_v_cnt       = r_v_cnt;
  assign o_h_wrap      = w_tick && w_h_end;
  assign o_v_wrap      = w_tick && w_h_end && w_v_end;
  assign o_ctl.hsync_n = !in_window(r_h_cnt, H_ACTIVE + H_FP, H_SYNC);
  assign o_ctl.vsync_n = !in_window(r_v_cnt, V_ACTIVE + V_FP, V_SYNC);
  assign o_ctl.de      = (r_h_cnt < cnt_t'(H_ACTIVE)) && (r_v_cnt < cnt_t'(V_ACTIVE));
  assign o_vblank      = (r_v_cnt >= cnt_t'(V_ACTIVE));
  assign o_frame_start = r_frame_start;

endmodule

// File: rtl/vga_scanout.sv
// VRAM-to-VGA scanout: texel address generation, VRAM strobes and 2-tick pixel pipeline.
module vga_scanout
  import vga_scanout_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = HActive,
  parameter int unsigned H_FP       = HFp,
  parameter int unsigned H_SYNC     = HSync,
  parameter int unsigned H_BP       = HBp,
  parameter int unsigned V_ACTIVE   = VActive,
  parameter int unsigned V_FP       = VFp,
  parameter int unsigned V_SYNC     = VSync,
  parameter int unsigned V_BP       = VBp,
  parameter int unsigned CLK_DIV    = ClkDiv,
  parameter int unsigned SCALE_LOG2 = ScaleLog2,
  parameter int unsigned FB_W       = FbW,
  parameter logic [15:0] BASE_ADDR  = BaseAddr
) (
  input  logic                 clk,
  input  logic                 rst,
  vga_scanout_if.master        vram,
  output rgb_t                 rgb,
  output logic                 hsync_n,
  output logic                 vsync_n,
  output logic                 de,
  output logic                 vblank,
  output logic                 frame_start
);

  logic     w_tick;
  logic     w_h_wrap;
  logic     w_v_wrap;
  cnt_t     w_h_cnt;
  cnt_t     w_v_cnt;
  cnt_t     w_v_next;
  vid_ctl_t w_ctl;
  logic     w_vblank;
  logic     w_frame_start;
  logic     w_row_step;

  vaddr_t   r_row_base;
  vaddr_t   r_addr;
  vid_ctl_t r_ctl_s1;
  vid_ctl_t r_ctl_s2;
  rgb_t     r_rgb;

  vga_scanout_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .CLK_DIV  (CLK_DIV)
  ) u_timing (
    .clk           (clk),
    .rst           (rst),
    .o_tick        (w_tick),
    .o_h_cnt       (w_h_cnt),
    .o_v_cnt       (w_v_cnt),
    .o_h_wrap      (w_h_wrap),
    .o_v_wrap      (w_v_wrap),
    .o_ctl         (w_ctl),
    .o_vblank      (w_vblank),
    .o_frame_start (w_frame_start)
  );

  // Next line starts a new texel row when its index is a multiple of the scale factor.
  assign w_v_next   = w_v_cnt + 1'b1;
  assign w_row_step = ((w_v_next & cnt_t'((1 << SCALE_LOG2) - 1)) == '0) &&
                      (w_v_next < cnt_t'(V_ACTIVE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row_base <= BASE_ADDR;
    end else if (w_v_wrap) begin
      r_row_base <= BASE_ADDR;
    end else if (w_h_wrap && w_row_step) begin
      r_row_base <= r_row_base + vaddr_t'(FB_W);
    end
  end

  // Stage 0 issues the address; stage 1 captures VRAM data, masked so a floating bus never
  // reaches the pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr   <= BASE_ADDR;
      r_ctl_s1 <= CtlIdle;
      r_ctl_s2 <= CtlIdle;
      r_rgb    <= ColBlack;
    end else if (w_tick) begin
      r_ctl_s1 <= w_ctl;
      if (w_ctl.de) r_addr <= r_row_base + vaddr_t'(w_h_cnt >> SCALE_LOG2);
      r_ctl_s2 <= r_ctl_s1;
      r_rgb    <= r_ctl_s1.de ? vram.Data_bus : ColBlack;
    end
  end

  assign vram.Address_bus = r_addr;
  assign vram.cs          = ~r_ctl_s1.de;
  assign vram.oe          = ~r_ctl_s1.de;
  assign vram.rw          = 1'b1;
  assign rgb              = r_rgb;
  assign hsync_n          = r_ctl_s2.hsync_n;
  assign vsync_n          = r_ctl_s2.vsync_n;
  assign de               = r_ctl_s2.de;
  assign vblank           = w_vblank;
  assign frame_start      = w_frame_start;

endmodule

// File: tb/tb_vga_scanout.sv
// Two scanout instances (base 0x0000 and 0xFFF0, shortened vertical timing) checked every clk
// against an arithmetic model of screen position versus elapsed pixel ticks.
module tb_vga_scanout;

  localparam int HA = 640, HFP = 16, HS = 96, HBP = 48;
  localparam int VA = 8, VFP = 2, VS = 2, VBP = 2;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FRAME = HT * VT;
  localparam int DIV = 2, SL = 2, FBW = 160;
  localparam int FRAME_CLKS = FRAME * DIV;

  typedef struct packed {
    logic [15:0] addr;
    logic        cs;
    logic [8:0]  rgb;
    logic        hs;
    logic        vs;
    logic        de;
    logic        vb;
    logic        fs;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_edges = 0;
  int   total = 0;
  int   bad = 0;

  logic [15:0] w_addr [2];
  logic        w_cs [2];
  logic        w_oe [2];
  logic        w_rw [2];
  logic [8:0]  w_rgb [2];
  logic        w_hs [2];
  logic        w_vs [2];
  logic        w_de [2];
  logic        w_vb [2];
  logic        w_fs [2];

  always #10 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    vga_scanout_if u_if ();
    // Asynchronous VRAM: echoes the low address bits, bus undefined while deselected.
    assign u_if.Data_bus = (u_if.cs | u_if.oe) ? 9'bx : u_if.Address_bus[8:0];

    vga_scanout #(
      .V_ACTIVE  (VA),
      .V_FP      (VFP),
      .V_SYNC    (VS),
      .V_BP      (VBP),
      .BASE_ADDR ((g == 0) ? 16'h0000 : 16'hFFF0)
    ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .vram        (u_if),
      .rgb         (w_rgb[g]),
      .hsync_n     (w_hs[g]),
      .vsync_n     (w_vs[g]),
      .de          (w_de[g]),
      .vblank      (w_vb[g]),
      .frame_start (w_fs[g])
    );

    assign w_addr[g] = u_if.Address_bus;
    assign w_cs[g]   = u_if.cs;
    assign w_oe[g]   = u_if.oe;
    assign w_rw[g]   = u_if.rw;
  end

  function automatic logic [15:0] base_of(input int g);
    return (g == 0) ? 16'h0000 : 16'hFFF0;
  endfunction

  function automatic logic [15:0] texel_addr(input logic [15:0] base, input int h, input int v);
    return base + 16'((v >> SL) * FBW + (h >> SL));
  endfunction

  // Outputs after n clk edges since reset release: pins lag the counters by whole pixel ticks.
  function automatic exp_t model(input int n, input logic [15:0] base);
    exp_t        e;
    int          t, q, h, v;
    logic [15:0] a;
    t      = n / DIV;
    e      = '{addr: base, cs: 1'b1, rgb: 9'h000, hs: 1'b1, vs: 1'b1, de: 1'b0,
               vb: 1'b0, fs: 1'b0};
    q      = t % FRAME;
    e.vb   = (q / HT) >= VA;
    e.fs   = (n % DIV == 0) && (t > 0) && (q == VA * HT);
    if (t >= 1) begin
      q = (t - 1) % FRAME;
      h = q % HT;
      v = q / HT;
      if (h < HA && v < VA) begin
        e.addr = texel_addr(base, h, v);
        e.cs   = 1'b0;
      end else if (v < VA) begin
        e.addr = texel_addr(base, HA - 1, v);
      end else begin
        e.addr = texel_addr(base, HA - 1, VA - 1);
      end
    end
    if (t >= 2) begin
      q     = (t - 2) % FRAME;
      h     = q % HT;
      v     = q / HT;
      e.de  = (h < HA) && (v < VA);
      a     = texel_addr(base, h, v);
      e.rgb = e.de ? a[8:0] : 9'h000;
      e.hs  = !(h >= HA + HFP && h < HA + HFP + HS);
      e.vs  = !(v >= VA + VFP && v < VA + VFP + VS);
    end
    return e;
  endfunction

  task automatic chk(input string name, input int g, input logic [15:0] act,
                     input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] n=%0d: got %h want %h", name, g, n_edges, act, exp);
    end
  endtask

  task automatic check_reset_state();
    for (int g = 0; g < 2; g++) begin
      chk("rst_addr", g, w_addr[g], base_of(g));
      chk("rst_cs", g, 16'(w_cs[g]), 16'd1);
      chk("rst_oe", g, 16'(w_oe[g]), 16'd1);
      chk("rst_rgb", g, 16'(w_rgb[g]), 16'd0);
      chk("rst_hsync", g, 16'(w_hs[g]), 16'd1);
      chk("rst_vsync", g, 16'(w_vs[g]), 16'd1);
      chk("rst_de", g, 16'(w_de[g]), 16'd0);
      chk("rst_vblank", g, 16'(w_vb[g]), 16'd0);
      chk("rst_fstart", g, 16'(w_fs[g]), 16'd0);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) n_edges <= 0;
    else     n_edges <= n_edges + 1;
  end

  always @(negedge clk) begin
    exp_t e;
    for (int g = 0; g < 2; g++) begin
      e = model(n_edges, base_of(g));
      chk("addr", g, w_addr[g], e.addr);
      chk("cs", g, 16'(w_cs[g]), 16'(e.cs));
      chk("oe", g, 16'(w_oe[g]), 16'(e.cs));
      chk("rw", g, 16'(w_rw[g]), 16'd1);
      chk("rgb", g, 16'(w_rgb[g]), 16'(e.rgb));
      chk("hsync_n", g, 16'(w_hs[g]), 16'(e.hs));
      chk("vsync_n", g, 16'(w_vs[g]), 16'(e.vs));
      chk("de", g, 16'(w_de[g]), 16'(e.de));
      chk("vblank", g, 16'(w_vb[g]), 16'(e.vb));
      chk("frame_start", g, 16'(w_fs[g]), 16'(e.fs));
    end
    if (!rst) begin
      case (n_edges)
        3:     chk("lit_de_before", 0, 16'(w_de[0]), 16'd0);
        4: begin
          chk("lit_de_first", 0, 16'(w_de[0]), 16'd1);
          chk("lit_rgb_first", 0, 16'(w_rgb[0]), 16'h000);
          chk("lit_rgb_first", 1, 16'(w_rgb[1]), 16'h1F0);
        end
        128:   chk("lit_addr_ffff", 1, w_addr[1], 16'hFFFF);
        130: begin
          chk("lit_addr_wrap", 1, w_addr[1], 16'h0000);
          chk("lit_cs_wrap", 1, 16'(w_cs[1]), 16'd0);
        end
        1315:  chk("lit_hs_pre", 0, 16'(w_hs[0]), 16'd1);
        1316:  chk("lit_hs_fall", 0, 16'(w_hs[0]), 16'd0);
        1507:  chk("lit_hs_last", 0, 16'(w_hs[0]), 16'd0);
        1508:  chk("lit_hs_rise", 0, 16'(w_hs[0]), 16'd1);
        6400: begin
          chk("lit_addr_hold", 0, w_addr[0], 16'd159);
          chk("lit_cs_blank", 0, 16'(w_cs[0]), 16'd1);
        end
        6402:  chk("lit_row1_start", 0, w_addr[0], 16'd160);
        12480: chk("lit_last_texel", 0, w_addr[0], 16'd319);
        12799: chk("lit_vblank_pre", 0, 16'(w_vb[0]), 16'd0);
        12800: chk("lit_fstart", 0, 16'(w_fs[0]), 16'd1);
        12801: begin
          chk("lit_fstart_end", 0, 16'(w_fs[0]), 16'd0);
          chk("lit_vblank_on", 0, 16'(w_vb[0]), 16'd1);
        end
        13000: chk("lit_addr_vblank", 0, w_addr[0], 16'd319);
        default: ;
      endcase
    end
  end

  initial begin
    int run_clks;
    #1 rst = 1'b1;
    #1 check_reset_state();
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Run past one full frame, then reset somewhere inside lines 3..6 of the next.
    run_clks = FRAME_CLKS + HT * DIV * $urandom_range(3, 6) + $urandom_range(0, HT * DIV - 1);
    repeat (run_clks) @(negedge clk);
    #($urandom_range(1, 8));
    rst = 1'b1;
    #1 check_reset_state();
    repeat (3) @(negedge clk);
    rst = 1'b0;

    repeat (FRAME_CLKS + HT * DIV) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
